mult_hilo_unit: RTL and testbench
=================================

Name: mult_hilo_unit

Overview:
- Iterative shift-add multiplier with architectural HI/LO registers for the single-cycle MIPS datapath.
- Sits directly downstream of the control unit. It consumes that unit's hi_lo strobe (the mult/multu write request) and the mf_hi_lo read request.
- Returns the mfhi/mflo write-back value and a stall that holds the PC while a multiply is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  multiply request, driven by the control unit's hi_lo; level, held while the instruction is stalled.
signed_op  input  1  1 = mult (two's complement), 0 = multu; sampled with start.
a  input  WIDTH  rs operand; sampled on the accept edge.
b  input  WIDTH  rt operand; sampled on the accept edge.
mf_sel  input  1  1 = read HI, 0 = read LO (mfhi/mflo select).
mf_out  output  WIDTH  combinational mux of HI/LO per mf_sel.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
busy  output  1  state != IDLE.
done  output  1  registered one-cycle pulse following the HI/LO update.
stall  output  1  busy | (start & ~done); drives the PC/regfile write hold.

Behaviour:
- Reset (async, any state, including mid-multiply): state = IDLE; hi = lo = 0; done = 0; internal accumulator, multiplicand, multiplier and counter = 0. Any in-flight operation is discarded.
- States: IDLE, MUL, FIN.
- IDLE:
  - Accept when start & ~done. On the accept edge, capture |a|, |b| (magnitudes only if signed_op, else raw), neg = signed_op & (a[MSB] ^ b[MSB]); clear the 2*WIDTH accumulator; count = 0; go to MUL.
  - start while done = 1 is ignored. This prevents the held multu instruction re-triggering in its release cycle.
- MUL (WIDTH cycles):
  - Each edge: if multiplier LSB = 1, add the multiplicand (zero-extended to 2*WIDTH) to the accumulator.
  - Then shift the multiplicand left by 1, shift the multiplier right by 1, and increment count.
  - Leave for FIN on the edge where count = WIDTH-1, so exactly WIDTH MUL cycles occur.
- FIN (1 cycle):
  - On the exit edge: product = neg ? -acc : acc (2*WIDTH two's complement). hi <= product[2W-1:W], lo <= product[W-1:0], done <= 1, state <= IDLE.
- done is 1 for exactly the cycle after FIN, then returns to 0.
- Latency: accept at cycle 0; MUL occupies cycles 1..WIDTH; FIN at cycle WIDTH+1; HI/LO new and done = 1 at cycle WIDTH+2.
- stall is high for cycles 0..WIDTH+1 (WIDTH+2 cycles total) and low at cycle WIDTH+2, so the PC advances exactly once.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which is representable unsigned; no special case.
- A zero product with neg = 1 yields 0; negating 0 is inherently 0.
- HI/LO hold their value whenever the unit is not in FIN.
- mf_out reflects the old HI/LO during busy. The program-order hazard is covered by stall.
- start and operand changes during MUL/FIN are ignored.

Test Plan:
1. Unsigned latency: multu a = 7, b = 6 -> stall high exactly 34 cycles (WIDTH = 32); done pulse at cycle 34; lo = 0x0000002A, hi = 0.
2. Unsigned max: a = b = 0xFFFFFFFF, signed_op = 0 -> hi = 0xFFFFFFFE, lo = 0x00000001. The same operands with signed_op = 1 -> hi = 0, lo = 1.
3. Signed cases:
   - mult a = 0xFFFFFFFD (-3), b = 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
   - a = b = 0x80000000 -> hi = 0x40000000, lo = 0.
   - a = 0, b = 0x80000000 -> hi = lo = 0.
4. Start held high through done (models the stalled instruction) -> exactly one multiply, no second busy period; stall falls in the done cycle. Back-to-back start after one idle cycle is accepted normally.
5. Async reset asserted in MUL cycle 10 -> hi = lo = 0, busy = stall = done = 0 immediately, without waiting for a clock edge; a subsequent multiply completes correctly.
6. mf_out mux: after test 3's first case, mf_sel = 1 -> 0xFFFFFFFF; mf_sel = 0 -> 0xFFFFFFF1. During a new multiply, mf_out keeps the previous values until the done cycle.

Source files
------------

// File: rtl/mult_hilo_unit.sv
// Iterative shift-add multiplier with architectural HI/LO registers (mult/multu, mfhi/mflo).
// Latency: accept edge, WIDTH MUL cycles, one FIN cycle; HI/LO and done valid WIDTH+2 cycles after accept.
// Backpressure: stall holds the PC from the request cycle until the done cycle; start is ignored while busy or done.
module mult_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] mf_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] product;

  // Operand magnitudes for the accept edge and the sign-corrected final product.
  // The magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    a_mag   = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag   = (signed_op && b[WIDTH-1]) ? -b : b;
    product = neg ? -acc : acc;
  end

  // Control FSM and datapath: accept, WIDTH shift-add steps, then commit to HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // done gating keeps the still-held instruction from re-triggering in its release cycle.
          if (start && !done) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          hi    <= product[2*WIDTH-1:WIDTH];
          lo    <= product[WIDTH-1:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign stall  = busy | (start & ~done);
  assign mf_out = mf_sel ? hi : lo;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: scoreboard of expected {HI,LO} pushed at issue, popped at done.
// Checks stall length, done pulse, HI/LO, mf_out mux, held-start behaviour and async reset mid-multiply.
// Inputs driven 1ns after the rising edge; outputs sampled on the falling edge.
module tb_mult_hilo_unit;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              signed_op;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              mf_sel;
  logic [WIDTH-1:0]  mf_out;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic              busy;
  logic              done;
  logic              stall;

  int                checks = 0;
  int                errors = 0;
  logic [2*WIDTH-1:0] sb[$];
  logic [WIDTH-1:0]  prev_hi = '0;
  logic [WIDTH-1:0]  prev_lo = '0;

  mult_hilo_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .signed_op(signed_op),
    .a        (a),
    .b        (b),
    .mf_sel   (mf_sel),
    .mf_out   (mf_out),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference product: full-width multiply of sign- or zero-extended operands.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  // Issue one multiply with start held through the done cycle, as a stalled instruction would.
  // abort_at > 0 asserts reset during that MUL cycle instead of completing.
  task automatic do_mult(input logic [31:0] xa, input logic [31:0] xb, input logic s, input int abort_at);
    logic [63:0] e;
    int n;
    @(posedge clk);
    #1;
    a = xa;
    b = xb;
    signed_op = s;
    start = 1'b1;
    sb.push_back(model(xa, xb, s));
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      // n-1 is the cycle index relative to the request cycle
      if (n == 3) begin
        a = ~xa;
        b = xb + 32'd1;
        signed_op = ~s;
      end
      if (n == 6) chk("mf_out_busy", mf_out, mf_sel ? prev_hi : prev_lo);
      if (abort_at != 0 && n == abort_at + 1) begin
        rst = 1'b1;
        start = 1'b0;
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        void'(sb.pop_front());
        prev_hi = '0;
        prev_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("stall_cycles", n, WIDTH + 2);
    chk("done_pulse", done, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("hi", hi, e[63:32]);
      chk("lo", lo, e[31:0]);
      prev_hi = e[63:32];
      prev_lo = e[31:0];
      mf_sel = 1'b1;
      #1;
      chk("mf_out_hi", mf_out, e[63:32]);
      mf_sel = 1'b0;
      #1;
      chk("mf_out_lo", mf_out, e[31:0]);
    end
    // Instruction released after the done cycle.
    @(posedge clk);
    #1;
    start = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    chk("no_retrigger_busy", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    a = '0;
    b = '0;
    mf_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_stall", stall, 0);
    rst = 1'b0;

    // Unsigned latency and small product
    do_mult(32'd7, 32'd6, 1'b0, 0);
    // Unsigned and signed all-ones
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    // Signed cases; mf_sel = 1 during the busy period of the first
    mf_sel = 1'b1;
    do_mult(32'hFFFF_FFFD, 32'd5, 1'b1, 0);
    mf_sel = 1'b1;
    do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    do_mult(32'h0000_0000, 32'h8000_0000, 1'b1, 0);
    // Async reset in MUL cycle 10, then a normal multiply
    do_mult(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 10);
    do_mult(32'hFFFF_FF9C, 32'h0000_0123, 1'b1, 0);
    // A few random operands of both signedness
    for (int i = 0; i < 4; i++) begin
      do_mult($urandom, $urandom, 1'(i), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
